// File: rtl/hash_vga_grid.sv
// VGA raster generator drawing a hash as a ROWS x COLS grid of solid colour cells.
// Optional white cell borders are compiled in with `define HASH_VGA_GRIDLINE_EN.
module hash_vga_grid #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   HASH_W   = 160,
  parameter int   COLS     = 8,
  parameter int   ROWS     = 4,
  parameter int   CELL_W   = 80,
  parameter int   CELL_H   = 120,
  parameter int   BPC      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pix_en,
  input  logic [HASH_W-1:0] i_hash,
  input  logic              i_hash_valid,
  output logic              o_hash_ready,
  output logic              o_frame_start,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic [3:0]        o_red,
  output logic [3:0]        o_green,
  output logic [3:0]        o_blue
);

  localparam int H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOT);
  localparam int VW      = $clog2(V_TOT);
  localparam int CXW     = $clog2(CELL_W + 1);
  localparam int CYW     = $clog2(CELL_H + 1);
  localparam int CIW     = $clog2(COLS + 1);
  localparam int RIW     = $clog2(ROWS + 1);
  localparam int NCELL   = COLS * ROWS;
  localparam int KW      = $clog2(NCELL + 1);
  localparam int FIELD_W = 3 * BPC;
  localparam int GRID_B  = FIELD_W * NCELL;
  localparam int EXT_W   = ((HASH_W > GRID_B) ? HASH_W : GRID_B) + FIELD_W;

  localparam logic [HW-1:0]  H_LAST     = HW'(H_TOT - 1);
  localparam logic [HW-1:0]  H_ACT_C    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  H_SS       = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  H_SE       = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  V_LAST     = VW'(V_TOT - 1);
  localparam logic [VW-1:0]  V_ACT_C    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0]  V_SS       = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  V_SE       = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CXW-1:0] CX_LAST    = CXW'(CELL_W - 1);
  localparam logic [CYW-1:0] CY_LAST    = CYW'(CELL_H - 1);
  localparam logic [CIW-1:0] COLS_C     = CIW'(COLS);
  localparam logic [RIW-1:0] ROWS_C     = RIW'(ROWS);
  localparam logic [KW-1:0]  COLS_K     = KW'(COLS);

  function automatic logic [3:0] chan(input logic [BPC-1:0] v);
    logic [7:0] t;
    t = 8'(v) << (8 - BPC);
    return t[7:4];
  endfunction

  logic [HW-1:0]  r_h_cnt;
  logic [VW-1:0]  r_v_cnt;
  logic [CXW-1:0] r_col_px;
  logic [CIW-1:0] r_col_idx;
  logic [CYW-1:0] r_row_px;
  logic [RIW-1:0] r_row_idx;
  logic           w_h_last, w_v_last;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  // Stage p0: raster and cell counters; cell indices saturate at COLS/ROWS (= outside grid)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_col_px  <= '0;
      r_col_idx <= '0;
      r_row_px  <= '0;
      r_row_idx <= '0;
    end else if (i_pix_en) begin
      if (w_h_last) begin
        r_h_cnt   <= '0;
        r_col_px  <= '0;
        r_col_idx <= '0;
        if (w_v_last) begin
          r_v_cnt   <= '0;
          r_row_px  <= '0;
          r_row_idx <= '0;
        end else begin
          r_v_cnt <= r_v_cnt + 1'b1;
          if (r_row_px == CY_LAST) begin
            r_row_px <= '0;
            if (r_row_idx != ROWS_C) r_row_idx <= r_row_idx + 1'b1;
          end else begin
            r_row_px <= r_row_px + 1'b1;
          end
        end
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
        if (r_col_px == CX_LAST) begin
          r_col_px <= '0;
          if (r_col_idx != COLS_C) r_col_idx <= r_col_idx + 1'b1;
        end else begin
          r_col_px <= r_col_px + 1'b1;
        end
      end
    end
  end

  logic          w_in_grid;
  logic [KW-1:0] w_k;
  logic          r_grid_p1, r_hs_p1, r_vs_p1, r_fs_p1;
  logic [KW-1:0] r_k_p1;

  assign w_in_grid = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C) &&
                     (r_col_idx < COLS_C) && (r_row_idx < ROWS_C);
  assign w_k       = KW'(r_row_idx) * COLS_K + KW'(r_col_idx);

  // Stage p1: cell index, grid flag, raw syncs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grid_p1 <= 1'b0;
      r_k_p1    <= '0;
      r_hs_p1   <= ~SYNC_POL;
      r_vs_p1   <= ~SYNC_POL;
      r_fs_p1   <= 1'b0;
    end else if (i_pix_en) begin
      r_grid_p1 <= w_in_grid;
      r_k_p1    <= w_in_grid ? w_k : '0;
      r_hs_p1   <= (r_h_cnt >= H_SS && r_h_cnt < H_SE) ? SYNC_POL : ~SYNC_POL;
      r_vs_p1   <= (r_v_cnt >= V_SS && r_v_cnt < V_SE) ? SYNC_POL : ~SYNC_POL;
      r_fs_p1   <= (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

`ifdef HASH_VGA_GRIDLINE_EN
  logic r_border_p1;
  always_ff @(posedge clk) begin
    if (rst)           r_border_p1 <= 1'b0;
    else if (i_pix_en) r_border_p1 <= (r_col_px == '0) || (r_row_px == '0);
  end
`endif

  logic [HASH_W-1:0]  r_disp, r_pend;
  logic               r_pend_full;
  logic               w_accept, w_swap;
  logic [EXT_W-1:0]   w_disp_ext;
  logic [FIELD_W-1:0] w_field;

  assign o_hash_ready = ~r_pend_full;
  assign w_accept     = i_hash_valid & ~r_pend_full;
  assign w_swap       = i_pix_en & w_h_last & (r_v_cnt == V_ACT_LAST);
  assign w_disp_ext   = EXT_W'(r_disp);
  assign w_field      = w_disp_ext[FIELD_W*r_k_p1 +: FIELD_W];

  // Digest swap happens at the end of the last active line, so a frame never tears
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp      <= '0;
      r_pend_full <= 1'b0;
    end else begin
      if (w_swap && r_pend_full) r_disp <= r_pend;
      if (w_accept)    r_pend_full <= 1'b1;
      else if (w_swap) r_pend_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_pend <= i_hash;
  end

  // Stage p2: colour lookup and aligned outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      o_red         <= 4'h0;
      o_green       <= 4'h0;
      o_blue        <= 4'h0;
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
      o_frame_start <= 1'b0;
    end else if (i_pix_en) begin
      o_hsync       <= r_hs_p1;
      o_vsync       <= r_vs_p1;
      o_frame_start <= r_fs_p1;
      if (!r_grid_p1) begin
        o_red   <= 4'h0;
        o_green <= 4'h0;
        o_blue  <= 4'h0;
`ifdef HASH_VGA_GRIDLINE_EN
      end else if (r_border_p1) begin
        o_red   <= 4'hF;
        o_green <= 4'hF;
        o_blue  <= 4'hF;
`endif
      end else begin
        o_red   <= chan(w_field[BPC-1:0]);
        o_green <= chan(w_field[2*BPC-1:BPC]);
        o_blue  <= chan(w_field[3*BPC-1:2*BPC]);
      end
    end else begin
      o_frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hash_vga_grid.sv
// Directed bench for hash_vga_grid on a shrunken 24x12 raster with a 3x2 grid of 4x3 cells.
module tb_hash_vga_grid;
  localparam int HT = 24;
  localparam int FR = 288;
  localparam logic [39:0] DIG_A = 40'hF1_D003_83AC;
  localparam logic [39:0] DIG_B = 40'h00_0000_01FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_pix_en = 1'b0;
  logic [39:0] i_hash = '0;
  logic        i_hash_valid = 1'b0;
  logic        o_hash_ready, o_frame_start, o_hsync, o_vsync;
  logic [3:0]  o_red, o_green, o_blue;
  logic [11:0] rgb;
  int          pos = 0;
  int          total = 0;
  int          bad = 0;

  hash_vga_grid #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .HASH_W(40), .COLS(3), .ROWS(2),
    .CELL_W(4), .CELL_H(3), .BPC(3)
  ) dut (
    .clk(clk), .rst(rst), .i_pix_en(i_pix_en), .i_hash(i_hash),
    .i_hash_valid(i_hash_valid), .o_hash_ready(o_hash_ready),
    .o_frame_start(o_frame_start), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
  );

  always #5 clk = ~clk;
  assign rgb = {o_red, o_green, o_blue};

  // Enabled edges since reset; output after edge n shows raster pixel n-2
  always @(posedge clk) begin
    if (rst)           pos <= 0;
    else if (i_pix_en) pos <= pos + 1;
  end

  function automatic int px(input int fr, input int x, input int y);
    return fr * FR + y * HT + x + 2;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_pix_en = 1'b1; i_hash_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    while (pos < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (pos != target) begin
      total++; bad++;
      $display("FAIL wait_pos: reached %0d, wanted %0d", pos, target);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; i_pix_en = 1'b1; i_hash_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (o_hash_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", o_hash_ready); end
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL rst_rgb: got %h want 000", rgb); end
    total++; if (o_hsync !== 1'b1) begin bad++; $display("FAIL rst_hsync: got %b want 1", o_hsync); end
    total++; if (o_vsync !== 1'b1) begin bad++; $display("FAIL rst_vsync: got %b want 1", o_vsync); end
    total++; if (o_frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs: got %b want 0", o_frame_start); end
    rst = 1'b0;
  endtask

  task automatic test_timing();
    do_reset();
    total++; if (o_frame_start !== 1'b0) begin bad++; $display("FAIL fs_pos0: got %b want 0", o_frame_start); end
    wait_pos(2);
    total++; if (o_frame_start !== 1'b1) begin bad++; $display("FAIL fs_pos2: got %b want 1", o_frame_start); end
    wait_pos(3);
    total++; if (o_frame_start !== 1'b0) begin bad++; $display("FAIL fs_pos3: got %b want 0", o_frame_start); end
    wait_pos(px(0, 17, 0));
    total++; if (o_hsync !== 1'b1) begin bad++; $display("FAIL hs_x17: got %b want 1", o_hsync); end
    wait_pos(px(0, 18, 0));
    total++; if (o_hsync !== 1'b0) begin bad++; $display("FAIL hs_x18: got %b want 0", o_hsync); end
    wait_pos(px(0, 20, 0));
    total++; if (o_hsync !== 1'b0) begin bad++; $display("FAIL hs_x20: got %b want 0", o_hsync); end
    wait_pos(px(0, 21, 0));
    total++; if (o_hsync !== 1'b1) begin bad++; $display("FAIL hs_x21: got %b want 1", o_hsync); end
    wait_pos(px(0, 1, 1));
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL rgb_nodigest: got %h want 000", rgb); end
    wait_pos(px(0, 0, 8));
    total++; if (o_vsync !== 1'b1) begin bad++; $display("FAIL vs_y8: got %b want 1", o_vsync); end
    wait_pos(px(0, 0, 9));
    total++; if (o_vsync !== 1'b0) begin bad++; $display("FAIL vs_y9: got %b want 0", o_vsync); end
    wait_pos(px(0, 23, 10));
    total++; if (o_vsync !== 1'b0) begin bad++; $display("FAIL vs_y10: got %b want 0", o_vsync); end
    wait_pos(px(0, 0, 11));
    total++; if (o_vsync !== 1'b1) begin bad++; $display("FAIL vs_y11: got %b want 1", o_vsync); end
  endtask

  task automatic test_periods(input bit half);
    int first = -1, second = -1, hl = 0, vl = 0;
    int exp_p, exp_h, exp_v;
    exp_p = half ? 2 * FR : FR;
    exp_h = half ? 72 : 36;
    exp_v = half ? 96 : 48;
    do_reset();
    for (int i = 0; i < 1400; i++) begin
      @(negedge clk);
      if (o_frame_start === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (first >= 0 && second < 0) begin
        if (o_hsync === 1'b0) hl++;
        if (o_vsync === 1'b0) vl++;
      end
      if (half) i_pix_en = ~i_pix_en;
    end
    i_pix_en = 1'b1;
    total++; if (second - first !== exp_p) begin bad++; $display("FAIL frame_period(half=%0d): got %0d want %0d", half, second - first, exp_p); end
    total++; if (hl !== exp_h) begin bad++; $display("FAIL hsync_low_clks(half=%0d): got %0d want %0d", half, hl, exp_h); end
    total++; if (vl !== exp_v) begin bad++; $display("FAIL vsync_low_clks(half=%0d): got %0d want %0d", half, vl, exp_v); end
  endtask

  task automatic test_hash_display();
    do_reset();
    i_hash = DIG_A; i_hash_valid = 1'b1;
    @(negedge clk);
    i_hash_valid = 1'b0;
    total++; if (o_hash_ready !== 1'b0) begin bad++; $display("FAIL ready_after_accept: got %b want 0", o_hash_ready); end
    wait_pos(px(0, 1, 1));
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL frame0_cell0: got %h want 000", rgb); end
    wait_pos(191);
    total++; if (o_hash_ready !== 1'b0) begin bad++; $display("FAIL ready_pre_swap: got %b want 0", o_hash_ready); end
    wait_pos(193);
    total++; if (o_hash_ready !== 1'b1) begin bad++; $display("FAIL ready_post_swap: got %b want 1", o_hash_ready); end
    wait_pos(px(1, 1, 1));
    total++; if (rgb !== 12'h8AC) begin bad++; $display("FAIL cell0: got %h want 8AC", rgb); end
    wait_pos(px(1, 4, 1));
`ifdef HASH_VGA_GRIDLINE_EN
    total++; if (rgb !== 12'hFFF) begin bad++; $display("FAIL cell1_border: got %h want FFF", rgb); end
`else
    total++; if (rgb !== 12'h20E) begin bad++; $display("FAIL cell1_edge: got %h want 20E", rgb); end
`endif
    wait_pos(px(1, 5, 1));
    total++; if (rgb !== 12'h20E) begin bad++; $display("FAIL cell1: got %h want 20E", rgb); end
    wait_pos(px(1, 9, 1));
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL cell2: got %h want 000", rgb); end
    wait_pos(px(1, 13, 1));
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL right_of_grid: got %h want 000", rgb); end
    wait_pos(px(1, 20, 1));
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL hblank: got %h want 000", rgb); end
    wait_pos(px(1, 1, 4));
    total++; if (rgb !== 12'h4E0) begin bad++; $display("FAIL cell3: got %h want 4E0", rgb); end
    wait_pos(px(1, 6, 4));
    total++; if (rgb !== 12'hE20) begin bad++; $display("FAIL cell4_hashedge: got %h want E20", rgb); end
    wait_pos(px(1, 10, 5));
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL cell5_beyond_hash: got %h want 000", rgb); end
    wait_pos(px(1, 2, 7));
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL below_grid: got %h want 000", rgb); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_hash = DIG_A; i_hash_valid = 1'b1;
    @(negedge clk);
    total++; if (o_hash_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_a: got %b want 0", o_hash_ready); end
    i_hash = DIG_B;
    wait_pos(100);
    total++; if (o_hash_ready !== 1'b0) begin bad++; $display("FAIL b2b_stalled: got %b want 0", o_hash_ready); end
    wait_pos(192);
    total++; if (o_hash_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_swap: got %b want 1", o_hash_ready); end
    @(negedge clk);
    i_hash_valid = 1'b0;
    total++; if (o_hash_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_b: got %b want 0", o_hash_ready); end
    wait_pos(px(1, 1, 1));
    total++; if (rgb !== 12'h8AC) begin bad++; $display("FAIL b2b_frame1_a: got %h want 8AC", rgb); end
    wait_pos(px(2, 1, 1));
    total++; if (rgb !== 12'hEEE) begin bad++; $display("FAIL b2b_frame2_b: got %h want EEE", rgb); end
  endtask

  task automatic test_swap_accept();
    do_reset();
    wait_pos(191);
    i_hash = DIG_A; i_hash_valid = 1'b1;
    @(negedge clk);
    i_hash_valid = 1'b0;
    total++; if (o_hash_ready !== 1'b0) begin bad++; $display("FAIL swapclk_ready: got %b want 0", o_hash_ready); end
    wait_pos(px(1, 1, 1));
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL swapclk_frame1: got %h want 000", rgb); end
    wait_pos(px(2, 1, 1));
    total++; if (rgb !== 12'h8AC) begin bad++; $display("FAIL swapclk_frame2: got %h want 8AC", rgb); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_hash = DIG_A; i_hash_valid = 1'b1;
    @(negedge clk);
    i_hash_valid = 1'b0;
    wait_pos(px(1, 1, 1));
    total++; if (rgb !== 12'h8AC) begin bad++; $display("FAIL mid_pre: got %h want 8AC", rgb); end
    i_hash = DIG_B; i_hash_valid = 1'b1;
    @(negedge clk);
    i_hash_valid = 1'b0;
    total++; if (o_hash_ready !== 1'b0) begin bad++; $display("FAIL mid_pend: got %b want 0", o_hash_ready); end
    wait_pos(FR + 5 * HT);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (o_hash_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", o_hash_ready); end
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL mid_rgb0: got %h want 000", rgb); end
    wait_pos(1);
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL mid_rgb1: got %h want 000", rgb); end
    total++; if (o_frame_start !== 1'b0) begin bad++; $display("FAIL mid_fs1: got %b want 0", o_frame_start); end
    wait_pos(2);
    total++; if (o_frame_start !== 1'b1) begin bad++; $display("FAIL mid_fs2: got %b want 1", o_frame_start); end
    wait_pos(px(0, 1, 1));
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL mid_disp_clear: got %h want 000", rgb); end
    wait_pos(px(1, 1, 1));
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL mid_pend_drop: got %h want 000", rgb); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_periods(1'b0);
    test_periods(1'b1);
    test_hash_display();
    test_back_to_back();
    test_swap_accept();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
